bus_arbiter2: RTL and testbench
===============================

# bus_arbiter2

Two-master Wishbone arbiter that shares the single CPU-side system bus between the bexkat2 CPU (master 0) and a second bus master (master 1: DMA or video fetch engine). It sits between the masters and the address decode/MMU, so all slaves (ROM, vectors, I/O, LED matrix, SDRAM controller) see exactly one master at a time. It provides round-robin grant on contention, bus lock for the length of a master's `cyc`, and a no-ack watchdog that terminates hung cycles with an error.

## Interface
- `TMO_CYCLES`, default 1023: consecutive un-acked strobe cycles before the watchdog fires. Legal range is 2..65535; the counter is 16 bits.
- `clk_i`  in  1  system clock (sysclock domain).
- `rst_i`  in  1  asynchronous, active-low reset.
- `m0_adr_i`/`m1_adr_i`  in  32  master address.
- `m0_dat_i`/`m1_dat_i`  in  32  master write data.
- `m0_dat_o`/`m1_dat_o`  out  32  read data; both equal `s_dat_i` at all times.
- `m0_sel_i`/`m1_sel_i`  in  4  byte enables.
- `m0_we_i`/`m1_we_i`  in  1  write enable.
- `m0_cyc_i`/`m1_cyc_i`  in  1  bus request / lock.
- `m0_stb_i`/`m1_stb_i`  in  1  transfer strobe.
- `m0_ack_o`/`m1_ack_o`  out  1  transfer acknowledge, routed only to the granted master.
- `m0_err_o`/`m1_err_o`  out  1  watchdog error pulse, routed only to the granted master.
- `s_adr_o`  out  32  slave-side address.
- `s_dat_o`  out  32  slave-side write data.
- `s_sel_o`  out  4  slave-side byte enables.
- `s_we_o`  out  1  slave-side write enable.
- `s_cyc_o`  out  1  slave-side cycle.
- `s_stb_o`  out  1  slave-side strobe.
- `s_dat_i`  in  32  slave read data, already muxed by chipselect.
- `s_ack_i`  in  1  slave acknowledge, already muxed.
- `grant_o`  out  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle. Registered.
- `timeout_o`  out  1  one-cycle pulse when the watchdog fires; feeds an I/O status/interrupt bit.

## Operation
- States:
  - IDLE: no grant.
  - BUS0: m0 owns the bus.
  - BUS1: m1 owns the bus.
  - The state register, `last` (the last master served), and the watchdog counter are the only sequential elements.
- IDLE transitions:
  - Only `m0_cyc_i` high → BUS0.
  - Only `m1_cyc_i` high → BUS1.
  - Both high → the master other than `last` wins.
  - Neither high → stay in IDLE.
  - `last` resets to 1, so m0 wins the first contention.
- Entering BUSn sets `last` = n.
- BUSn:
  - Slave outputs `s_adr/dat/sel/we/cyc/stb_o` are a combinational mux of master n's inputs.
  - `mn_ack_o` = `s_ack_i`. The other master's ack and err are held at 0.
  - The grant is held while `mn_cyc_i` is high, across any number of strobes (locked RMW / bursts).
- Release: in BUSn, `mn_cyc_i` low → IDLE on the next edge. During that cycle `s_cyc_o` and `s_stb_o` are already 0, because they follow the granted master's inputs.
- IDLE outputs: all `s_*_o` are 0 and all `mX_ack_o`/`mX_err_o` are 0. Any `s_ack_i` arriving in IDLE is dropped.
- Watchdog:
  - The counter clears when the state is IDLE, when `s_stb_o` is 0, or when `s_ack_i` is 1.
  - Otherwise it increments by 1 each cycle.
  - When the count equals `TMO_CYCLES - 1` with `s_stb_o` high and `s_ack_i` low:
    - `mn_err_o` and `timeout_o` pulse high for that cycle.
    - The counter clears.
    - The grant is retained; the master decides whether to drop `cyc`.
- Simultaneous `s_ack_i` and watchdog expiry: the ack wins. No err is raised and the counter clears.
- Granted master drops `cyc` mid-transfer (before ack): the bus is released normally and the counter clears on the IDLE transition.
- The non-granted master's `cyc` is ignored until IDLE. There is no preemption.

## Timing
- Grant latency: a request seen high in IDLE at edge k gives `grant_o` and the slave bus driven from cycle k+1. With no contention, the minimum is 1 cycle of arbitration overhead.
- One mandatory IDLE cycle between consecutive grants, including back-to-back requests from the same master.
- Data, ack and err paths are combinational, adding 0 cycles to slave latency.
- Worst-case wait for a master under contention: the other master's full locked tenure + 1 idle cycle + 1 grant cycle.
- Reset (`rst_i` low, asynchronous):
  - State becomes IDLE, `grant_o` = 00, `last` = 1, counter = 0, `timeout_o` = 0.
  - All `s_*_o`, `mX_ack_o` and `mX_err_o` go to 0 immediately.
  - Reset asserted mid-transfer abandons the transfer without an ack.
  - Release from reset is synchronous to `clk_i`; arbitration starts on the first edge after deassertion.

## Test plan
- Single master: m0 raises `cyc`/`stb` reading 0x00000004; the slave acks with 0xDEADBEEF two cycles later → `grant_o` = 01 the cycle after the request, `m0_dat_o` = 0xDEADBEEF, `m0_ack_o` is a single pulse coincident with `s_ack_i`, `m1_ack_o` stays 0.
- Contention: m0 and m1 raise `cyc` in the same cycle after reset → m0 is granted first. After m0 drops `cyc`, one IDLE cycle follows, then `grant_o` = 10. Repeating both requests → m0 is granted again (alternation).
- Lock: m1 holds `cyc` across three strobes (RMW at 0x70000010), with m0 requesting throughout → `grant_o` stays 10 for all three acks, and m0 gets the bus only after m1's `cyc` falls.
- Watchdog, `TMO_CYCLES` = 8: m0 strobes and the slave never acks → `m0_err_o` and `timeout_o` high exactly on the 8th strobe cycle, then the counter restarts. A variant where ack arrives on cycle 8 → ack is seen and no err is raised.
- Abort and stray ack: m0 drops `cyc` before ack, then the slave asserts `s_ack_i` in the following IDLE cycle → no ack reaches either master and `grant_o` = 00.
- Async reset: assert `rst_i` low mid-transfer in BUS1 between clock edges → all outputs are 0 before the next edge. After release, simultaneous requests → m0 is granted.

Source files
------------

// File: rtl/bus_arbiter2.sv
// Two-master Wishbone arbiter: round-robin grant on contention, bus lock for the owner's cyc, no-ack watchdog.
// Latency: 1 cycle from request (seen in IDLE) to grant; data/ack/err paths are combinational (0 added cycles).
// Backpressure: the non-granted master simply waits (no ack) until the owner drops cyc and one IDLE cycle passes.
//
// Ports:
//   clk_i, rst_i            system clock, asynchronous active-low reset
//   m0_*/m1_*               Wishbone master ports (adr/dat/sel/we/cyc/stb in, dat/ack/err out)
//   s_*                     single slave-side Wishbone port toward address decode / MMU
//   grant_o                 registered one-hot owner (bit0 = m0, bit1 = m1, 00 = idle)
//   timeout_o               one-cycle pulse when the watchdog terminates a hung strobe
//
// TMO_CYCLES must lie in 2..65535; the watchdog counter is 16 bits wide.

module bus_arbiter2 #(
    parameter int unsigned TMO_CYCLES = 1023
) (
    input  logic        clk_i,
    input  logic        rst_i,

    // master 0 (CPU)
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    // master 1 (DMA / video fetch)
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    // slave side
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    // status
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    // State encoding doubles as the one-hot grant vector, so grant_o is
    // taken straight from the state register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS0 = 2'b01,
        BUS1 = 2'b10
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_q,  last_d;   // last master served; 1 after reset so m0 wins first
    logic [15:0] cnt_q,   cnt_d;    // consecutive un-acked strobe cycles
    logic        wdog_fire;

    // ------------------------------------------------------------------
    // Sequential elements: state, last-served, watchdog counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o = state_q;

    // Read data is broadcast; only ack/err qualify which master consumes it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // ------------------------------------------------------------------
    // Slave-side mux and ack/err routing
    // ------------------------------------------------------------------
    always_comb begin
        s_adr_o  = 32'd0;
        s_dat_o  = 32'd0;
        s_sel_o  = 4'd0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;

        case (state_q)
            BUS0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
                m0_err_o = wdog_fire;
            end
            BUS1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
                m1_err_o = wdog_fire;
            end
            default: begin
                // IDLE: bus parked at zero, stray s_ack_i is dropped
            end
        endcase
    end

    assign timeout_o = wdog_fire;

    // ------------------------------------------------------------------
    // Watchdog: fires on the TMO_CYCLES-th consecutive un-acked strobe.
    // An ack in the same cycle wins, so fire is qualified by !s_ack_i.
    // ------------------------------------------------------------------
    always_comb begin
        wdog_fire = 1'b0;
        if ((state_q != IDLE) && s_stb_o && !s_ack_i && (cnt_q == TMO_LAST)) begin
            wdog_fire = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: arbitration in IDLE, lock while owner's cyc is high
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // contention: serve whichever master was not served last
                    if (last_q) begin
                        state_d = BUS0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = BUS1;
                        last_d  = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d = BUS0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = BUS1;
                    last_d  = 1'b1;
                end
            end
            BUS0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            BUS1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counter next-state kept separate from arbitration for readability.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) || (state_d == IDLE) || !s_stb_o || s_ack_i) begin
            // a released owner never carries a stale count into its next tenure
            cnt_d = 16'd0;
        end else if (wdog_fire) begin
            // grant is retained; the master decides whether to drop cyc
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
module tb_bus_arbiter2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_we_i = 1'b0, m0_cyc_i = 1'b0, m0_stb_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_cyc_i = 1'b0, m1_stb_i = 1'b0;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i = '0;
    logic        s_ack_i = 1'b0;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    bus_arbiter2 #(.TMO_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_masters();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick();
        #1;
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_ack_o, m1_ack_o} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs: got %b want 000000", {s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_ack_o, m1_ack_o});
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_1000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h2000_0000;
        #1;
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL cont_req_cycle: got %b want 00", grant_o); end
        tick();
        s_ack_i = 1'b1;
        #1;
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL cont_first_m0: got %b want 01", grant_o); end
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin failures++; $display("FAIL cont_ack_route: got %b want 10", {m0_ack_o, m1_ack_o}); end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        #1;
        checks++; if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0100) begin failures++; $display("FAIL cont_release: got %b want 0100", {grant_o, s_cyc_o, s_stb_o}); end
        tick();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL cont_idle_gap: got %b want 00", grant_o); end
        tick();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL cont_second_m1: got %b want 10", grant_o); end
        checks++; if (s_adr_o !== 32'h2000_0000) begin failures++; $display("FAIL cont_m1_adr: got %h want 20000000", s_adr_o); end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL cont_alternate: got %b want 01", grant_o); end
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_single();
        // last served is m0 now, but a lone m0 request must still win
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0004; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL single_grant: got %b want 01", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o, s_adr_o, s_sel_o} !== {2'b11, 32'h0000_0004, 4'hF}) begin
            failures++; $display("FAIL single_slave_bus: got %b %b %h %h", s_cyc_o, s_stb_o, s_adr_o, s_sel_o);
        end
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL single_no_early_ack: got %b want 0", m0_ack_o); end
        tick();
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin failures++; $display("FAIL single_ack: got %b want 10", {m0_ack_o, m1_ack_o}); end
        checks++; if (m0_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata: got %h want deadbeef", m0_dat_o); end
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        checks++; if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL single_ack_pulse: got %b want 0", m0_ack_o); end
        tick();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL single_release: got %b want 00", grant_o); end
    endtask

    task automatic test_lock();
        // last served is m0, so m1 wins this contention
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h7000_0010; m1_we_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            m1_stb_i = 1'b1; m1_we_i = (i == 2); s_ack_i = 1'b1;
            #1;
            checks++; if ({grant_o, m1_ack_o, m0_ack_o} !== 4'b1010) begin
                failures++; $display("FAIL lock_strobe%0d: got %b want 1010", i, {grant_o, m1_ack_o, m0_ack_o});
            end
            checks++; if (s_adr_o !== 32'h7000_0010) begin failures++; $display("FAIL lock_adr%0d: got %h want 70000010", i, s_adr_o); end
            tick();
            m1_stb_i = 1'b0; s_ack_i = 1'b0;
            #1;
            checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL lock_hold%0d: got %b want 10", i, grant_o); end
            tick();
        end
        m1_cyc_i = 1'b0; m1_we_i = 1'b0;
        tick();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL lock_idle: got %b want 00", grant_o); end
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL lock_m0_after: got %b want 01", grant_o); end
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        logic exp_err;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h3000_0000;
        tick();
        // strobe cycles 8 and 16 time out; ack on cycle 24 beats the expiry
        for (int n = 1; n <= 24; n++) begin
            s_ack_i = (n == 24);
            #1;
            exp_err = (n == 8) || (n == 16);
            checks++; if ({m0_err_o, timeout_o, m1_err_o, m0_ack_o} !== {exp_err, exp_err, 1'b0, (n == 24)}) begin
                failures++; $display("FAIL wdog_cycle%0d: err/tmo/m1err/ack got %b want %b", n,
                    {m0_err_o, timeout_o, m1_err_o, m0_ack_o}, {exp_err, exp_err, 1'b0, (n == 24)});
            end
            tick();
        end
        s_ack_i = 1'b0;
        #1;
        checks++; if ({m0_err_o, timeout_o, grant_o} !== 4'b0001) begin failures++; $display("FAIL wdog_after_ack: got %b want 0001", {m0_err_o, timeout_o, grant_o}); end
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_abort();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        checks++; if ({grant_o, m0_ack_o} !== 3'b010) begin failures++; $display("FAIL abort_release: got %b want 010", {grant_o, m0_ack_o}); end
        tick();
        s_ack_i = 1'b1;
        #1;
        checks++; if ({grant_o, m0_ack_o, m1_ack_o, s_cyc_o} !== 5'b0) begin
            failures++; $display("FAIL abort_stray_ack: got %b want 00000", {grant_o, m0_ack_o, m1_ack_o, s_cyc_o});
        end
        tick();
        s_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h4000_0040; m1_sel_i = 4'h3;
        tick();
        s_ack_i = 1'b1;
        #1;
        checks++; if ({grant_o, m1_ack_o} !== 3'b101) begin failures++; $display("FAIL areset_pre: got %b want 101", {grant_o, m1_ack_o}); end
        #1;
        rst_i = 1'b0;
        #1;
        checks++; if ({grant_o, m1_ack_o, m0_ack_o, s_cyc_o, s_stb_o} !== 6'b0) begin
            failures++; $display("FAIL areset_outputs: got %b want 000000", {grant_o, m1_ack_o, m0_ack_o, s_cyc_o, s_stb_o});
        end
        checks++; if ({s_adr_o, s_sel_o} !== 36'h0) begin failures++; $display("FAIL areset_bus: got %h want 0", {s_adr_o, s_sel_o}); end
        idle_masters();
        tick();
        tick();
        rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL areset_m0_first: got %b want 01", grant_o); end
        idle_masters();
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_lock();
        test_watchdog();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
